c2f_chunk_consumer: RTL and testbench

Parametrised consumer for the CPU->FPGA (C2F) chunk ring. It drains chunks between its read pointer and the host-written write pointer, one 64-bit QW at a time, from the on-chip chunk RAM. Consumption is rate-throttled by a fractional-rate control. Every consumed QW is folded into a 64-bit checksum and, in stream mode, also forwarded on a valid/ready stream. It sits between the TLP-receive path that fills the chunk RAM and the metrics DMA that publishes rdPtr to host memory. This generation adds configurable depth and chunk size, fractional rate, a stream mode and checksum clear.

---
 rtl/c2f_chunk_consumer.sv | 204 ++++++++++++++++++++
 tb/tb_c2f_chunk_consumer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2f_chunk_consumer.sv
// C2F chunk-ring consumer: drains QWs from the chunk RAM between the issue
// pointer and the host write pointer at a fractional rate, folds every
// consumed QW into a running checksum, and optionally forwards it on a
// valid/ready stream. rdPtr advances once the last QW of a chunk has left.
module c2f_chunk_consumer #(
    parameter int unsigned NUM_CHUNKS = 16,
    parameter int unsigned CHUNK_SIZE = 4096,
    localparam int unsigned CHUNK_BITS = $clog2(NUM_CHUNKS),
    localparam int unsigned QW_BITS    = $clog2(CHUNK_SIZE / 8)
) (
    input  logic                          pcieClk_in,
    input  logic                          reset_in,
    input  logic [CHUNK_BITS-1:0]         wrPtr_in,
    output logic [CHUNK_BITS-1:0]         rdPtr_out,
    output logic                          rdPtrUpdate_out,
    input  logic [8:0]                    rate_in,
    input  logic                          mode_in,
    output logic                          memRdEn_out,
    output logic [CHUNK_BITS+QW_BITS-1:0] memAddr_out,
    input  logic [63:0]                   memData_in,
    output logic [63:0]                   strmData_out,
    output logic                          strmValid_out,
    input  logic                          strmReady_in,
    input  logic                          csumClear_in,
    output logic [63:0]                   checksum_out
);

    localparam int unsigned QW_PER_CHUNK = CHUNK_SIZE / 8;
    localparam int unsigned ADDR_BITS    = CHUNK_BITS + QW_BITS;

    // One consumed QW plus the tags it carries through the pipeline.
    typedef struct packed {
        logic        last;
        logic        mode;
        logic [63:0] data;
    } entry_t;

    // Issue side
    logic [CHUNK_BITS-1:0] issue_chunk;
    logic [QW_BITS-1:0]    issue_qw;
    logic [7:0]            acc;
    logic                  chunk_mode;
    logic                  mem_rd_en;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic                  rd_mode;
    logic                  rd_last;

    // Return side: RAM data is valid while pend is high
    logic                  pend;
    logic                  pend_mode;
    logic                  pend_last;

    // Two-entry skid FIFO, slot0 is the head
    entry_t                slot0;
    entry_t                slot1;
    logic [1:0]            cnt;
    logic                  strm_valid;

    // Consumer outputs
    logic [63:0]           csum;
    logic [CHUNK_BITS-1:0] rd_ptr;
    logic                  rd_ptr_upd;

    // Combinational control
    logic                  empty_c;
    logic [9:0]            sum_c;
    logic [2:0]            occ_c;
    logic                  eligible_c;
    logic                  issue_c;
    logic                  issue_mode_c;
    logic                  last_qw_c;
    entry_t                arr_c;
    logic                  head_exit_c;
    logic                  bypass_c;
    logic                  push_c;
    logic                  exit_c;
    entry_t                exit_entry_c;
    entry_t                n_slot0;
    entry_t                n_slot1;
    logic [1:0]            n_cnt;
    logic                  strm_valid_d;

    // Exit selection: a mode-0 arrival into an empty FIFO leaves at once,
    // a stored mode-0 head leaves unconditionally, a mode-1 head needs ready.
    always_comb begin
        arr_c        = '{last: pend_last, mode: pend_mode, data: memData_in};
        head_exit_c  = (cnt != 2'd0) && (!slot0.mode || strmReady_in);
        bypass_c     = pend && (cnt == 2'd0) && !pend_mode;
        push_c       = pend && !bypass_c;
        exit_c       = head_exit_c || bypass_c;
        exit_entry_c = bypass_c ? arr_c : slot0;
    end

    // Issue decision: slots still free after this cycle's exit, then rate gate.
    always_comb begin
        empty_c      = (issue_chunk == wrPtr_in);
        sum_c        = 10'(acc) + 10'(rate_in);
        occ_c        = 3'(mem_rd_en) + 3'(pend) + 3'(cnt) - 3'(exit_c);
        eligible_c   = !empty_c && (occ_c < 3'd2);
        issue_c      = eligible_c && (sum_c >= 10'd256);
        issue_mode_c = (issue_qw == '0) ? mode_in : chunk_mode;
        last_qw_c    = (issue_qw == QW_BITS'(QW_PER_CHUNK - 1));
    end

    // Skid FIFO next state: pop the head first, then append the arrival.
    always_comb begin
        n_slot0 = slot0;
        n_slot1 = slot1;
        n_cnt   = cnt;
        if (head_exit_c) begin
            n_slot0 = slot1;
            n_cnt   = cnt - 2'd1;
        end
        if (push_c) begin
            if (n_cnt == 2'd0) begin
                n_slot0 = arr_c;
            end else begin
                n_slot1 = arr_c;
            end
            n_cnt = n_cnt + 2'd1;
        end
        strm_valid_d = (n_cnt != 2'd0) && n_slot0.mode;
    end

    // Issue pointer, phase accumulator and RAM read pipeline.
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            issue_chunk <= '0;
            issue_qw    <= '0;
            acc         <= '0;
            chunk_mode  <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            rd_mode     <= 1'b0;
            rd_last     <= 1'b0;
            pend        <= 1'b0;
            pend_mode   <= 1'b0;
            pend_last   <= 1'b0;
        end else begin
            mem_rd_en <= issue_c;
            if (eligible_c) begin
                acc <= sum_c[7:0];
            end
            if (issue_c) begin
                mem_addr   <= {issue_chunk, issue_qw};
                rd_mode    <= issue_mode_c;
                rd_last    <= last_qw_c;
                chunk_mode <= issue_mode_c;
                if (last_qw_c) begin
                    issue_qw    <= '0;
                    issue_chunk <= issue_chunk + CHUNK_BITS'(1);
                end else begin
                    issue_qw <= issue_qw + QW_BITS'(1);
                end
            end
            pend      <= mem_rd_en;
            pend_mode <= rd_mode;
            pend_last <= rd_last;
        end
    end

    // Skid FIFO storage and registered stream valid.
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            slot0      <= '0;
            slot1      <= '0;
            cnt        <= '0;
            strm_valid <= 1'b0;
        end else begin
            slot0      <= n_slot0;
            slot1      <= n_slot1;
            cnt        <= n_cnt;
            strm_valid <= strm_valid_d;
        end
    end

    // Checksum accumulation and read-pointer advance on chunk completion.
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            csum       <= '0;
            rd_ptr     <= '0;
            rd_ptr_upd <= 1'b0;
        end else begin
            if (csumClear_in) begin
                csum <= exit_c ? exit_entry_c.data : 64'd0;
            end else if (exit_c) begin
                csum <= csum + exit_entry_c.data;
            end
            rd_ptr_upd <= exit_c && exit_entry_c.last;
            if (exit_c && exit_entry_c.last) begin
                rd_ptr <= rd_ptr + CHUNK_BITS'(1);
            end
        end
    end

    assign rdPtr_out       = rd_ptr;
    assign rdPtrUpdate_out = rd_ptr_upd;
    assign memRdEn_out     = mem_rd_en;
    assign memAddr_out     = mem_addr;
    assign strmData_out    = slot0.data;
    assign strmValid_out   = strm_valid;
    assign checksum_out    = csum;

endmodule

// File: tb/tb_c2f_chunk_consumer.sv
// Bench for c2f_chunk_consumer with a 4-chunk ring of 64-byte chunks.
// The RAM model returns each QW's own address as its data.
module tb_c2f_chunk_consumer;

    localparam int unsigned NC = 4;
    localparam int unsigned CS = 64;
    localparam int unsigned CB = 2;
    localparam int unsigned AB = 5;

    logic          clk;
    logic          reset_in;
    logic [CB-1:0] wrPtr_in;
    logic [CB-1:0] rdPtr_out;
    logic          rdPtrUpdate_out;
    logic [8:0]    rate_in;
    logic          mode_in;
    logic          memRdEn_out;
    logic [AB-1:0] memAddr_out;
    logic [63:0]   memData_in;
    logic [63:0]   strmData_out;
    logic          strmValid_out;
    logic          strmReady_in;
    logic          csumClear_in;
    logic [63:0]   checksum_out;

    int checks;
    int failures;
    int addr_log[$];
    int upd_total;

    c2f_chunk_consumer #(
        .NUM_CHUNKS(NC),
        .CHUNK_SIZE(CS)
    ) dut (
        .pcieClk_in     (clk),
        .reset_in       (reset_in),
        .wrPtr_in       (wrPtr_in),
        .rdPtr_out      (rdPtr_out),
        .rdPtrUpdate_out(rdPtrUpdate_out),
        .rate_in        (rate_in),
        .mode_in        (mode_in),
        .memRdEn_out    (memRdEn_out),
        .memAddr_out    (memAddr_out),
        .memData_in     (memData_in),
        .strmData_out   (strmData_out),
        .strmValid_out  (strmValid_out),
        .strmReady_in   (strmReady_in),
        .csumClear_in   (csumClear_in),
        .checksum_out   (checksum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data valid exactly one cycle after the read strobe, garbage otherwise
    always @(posedge clk) begin
        memData_in <= memRdEn_out ? 64'(memAddr_out) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // Read and rdPtr-update monitor
    always @(negedge clk) begin
        if (memRdEn_out) addr_log.push_back(int'(memAddr_out));
        if (rdPtrUpdate_out) upd_total = upd_total + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic do_reset(input int wr, input int rate, input int mode, input int ready);
        reset_in     = 1'b1;
        wrPtr_in     = CB'(wr);
        rate_in      = 9'(rate);
        mode_in      = 1'(mode);
        strmReady_in = 1'(ready);
        csumClear_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_in = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a read strobe at the given address, sampled on negedge
    task automatic wait_read(input int a);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (memRdEn_out && memAddr_out == AB'(a)) found = 1'b1;
        end
        check("wait_read_seen", 64'(found), 64'd1);
    endtask

    typedef struct {
        int     wr;
        int     rate;
        int     mode;
        int     ready;
        int     reads;
        int     rdptr;
        longint csum;
        int     valid;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int     base;
        int     ubase;
        int     exp_idx;
        int     issued;
        int     done_cnt;
        int     max_out;
        int     n;
        bit     prev_stall;
        logic [63:0] prev_data;
        bit     exp_rd;

        checks     = 0;
        failures   = 0;
        upd_total  = 0;
        reset_in   = 1'b1;
        memData_in = '0;

        vecs[0] = '{0, 256, 0, 1,  0, 0,   0, 0};
        vecs[1] = '{3, 256, 0, 1, 24, 3, 276, 0};
        vecs[2] = '{1, 256, 0, 1,  8, 1,  28, 0};
        vecs[3] = '{1, 128, 0, 1,  8, 1,  28, 0};
        vecs[4] = '{2,   0, 0, 1,  0, 0,   0, 0};
        vecs[5] = '{2,  64, 0, 1, 16, 2, 120, 0};
        vecs[6] = '{2, 256, 1, 1, 16, 2, 120, 0};
        vecs[7] = '{1, 256, 1, 0,  2, 0,   0, 1};
        vecs[8] = '{3, 511, 0, 1, 24, 3, 276, 0};

        // Reset state before anything runs
        do_reset(0, 256, 0, 1);
        check("reset_rdptr", 64'(rdPtr_out), 64'd0);
        check("reset_csum", checksum_out, 64'd0);
        check("reset_rden", 64'(memRdEn_out), 64'd0);

        // Table-driven steady-state runs from reset
        for (int v = 0; v < 9; v++) begin
            do_reset(vecs[v].wr, vecs[v].rate, vecs[v].mode, vecs[v].ready);
            base  = addr_log.size();
            ubase = upd_total;
            wait_cycles(120);
            check($sformatf("v%0d_reads", v), 64'(addr_log.size() - base), 64'(vecs[v].reads));
            check($sformatf("v%0d_rdptr", v), 64'(rdPtr_out), 64'(vecs[v].rdptr));
            check($sformatf("v%0d_csum", v), checksum_out, 64'(vecs[v].csum));
            check($sformatf("v%0d_valid", v), 64'(strmValid_out), 64'(vecs[v].valid));
            check($sformatf("v%0d_upds", v), 64'(upd_total - ubase), 64'(vecs[v].rdptr));
        end

        // Latency and sustained rate 256: first read the cycle after non-empty
        do_reset(0, 256, 0, 1);
        wait_cycles(3);
        wrPtr_in = CB'(1);
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            exp_rd = (j >= 1 && j <= 8);
            check($sformatf("lat_rden_%0d", j), 64'(memRdEn_out), 64'(exp_rd));
            if (exp_rd) check($sformatf("lat_addr_%0d", j), 64'(memAddr_out), 64'(j - 1));
            check($sformatf("lat_upd_%0d", j), 64'(rdPtrUpdate_out), 64'(j == 10));
        end
        check("lat_rdptr", 64'(rdPtr_out), 64'd1);

        // Rate 128: reads on alternating cycles
        do_reset(0, 128, 0, 1);
        wait_cycles(2);
        wrPtr_in = CB'(1);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            exp_rd = (j >= 2 && j <= 16 && (j % 2) == 0);
            check($sformatf("r128_rden_%0d", j), 64'(memRdEn_out), 64'(exp_rd));
        end

        // Rate dropped to 0 mid-chunk: reads stop, rdPtr holds
        do_reset(1, 128, 0, 1);
        base  = addr_log.size();
        ubase = upd_total;
        wait_read(3);
        rate_in = 9'd0;
        wait_cycles(30);
        check("stop_reads", 64'(addr_log.size() - base), 64'd4);
        check("stop_rdptr", 64'(rdPtr_out), 64'd0);
        check("stop_csum", checksum_out, 64'd6);
        check("stop_upds", 64'(upd_total - ubase), 64'd0);

        // Stream mode with random ready: in-order, stable under stall, <=2 outstanding
        do_reset(1, 256, 1, 0);
        exp_idx    = 0;
        issued     = 0;
        done_cnt   = 0;
        max_out    = 0;
        n          = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (exp_idx < 8 && n < 400) begin
            @(posedge clk);
            #1 strmReady_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            n = n + 1;
            if (memRdEn_out) issued = issued + 1;
            if (issued - done_cnt > max_out) max_out = issued - done_cnt;
            if (prev_stall) begin
                check("stall_valid", 64'(strmValid_out), 64'd1);
                check("stall_data", strmData_out, prev_data);
            end
            if (strmValid_out && strmReady_in) begin
                check("strm_data", strmData_out, 64'(exp_idx));
                exp_idx  = exp_idx + 1;
                done_cnt = done_cnt + 1;
            end
            prev_stall = strmValid_out && !strmReady_in;
            prev_data  = strmData_out;
        end
        check("strm_count", 64'(exp_idx), 64'd8);
        check("strm_outstanding_le2", 64'(max_out <= 2), 64'd1);
        strmReady_in = 1'b1;
        wait_cycles(10);
        check("strm_idle_valid", 64'(strmValid_out), 64'd0);
        check("strm_rdptr", 64'(rdPtr_out), 64'd1);
        check("strm_csum", checksum_out, 64'd28);

        // Mode latched per chunk: change mid-chunk 0 only affects chunk 1
        do_reset(2, 256, 0, 0);
        base = addr_log.size();
        wait_read(0);
        mode_in = 1'b1;
        wait_cycles(50);
        check("latch_reads", 64'(addr_log.size() - base), 64'd10);
        check("latch_rdptr", 64'(rdPtr_out), 64'd1);
        check("latch_csum", checksum_out, 64'd28);
        check("latch_valid", 64'(strmValid_out), 64'd1);
        check("latch_data", strmData_out, 64'd8);

        // Ring wrap: rdPtr 3 -> 0, then checksum clear coinciding with exit of 5
        do_reset(3, 256, 0, 1);
        wait_cycles(40);
        check("wrap_pre_rdptr", 64'(rdPtr_out), 64'd3);
        base = addr_log.size();
        wrPtr_in = CB'(0);
        wait_cycles(20);
        check("wrap_reads", 64'(addr_log.size() - base), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < addr_log.size())
                check($sformatf("wrap_addr_%0d", k), 64'(addr_log[base + k]), 64'(24 + k));
        end
        check("wrap_rdptr", 64'(rdPtr_out), 64'd0);
        check("wrap_csum", checksum_out, 64'd496);
        wrPtr_in = CB'(1);
        wait_read(5);
        @(posedge clk);
        #1 csumClear_in = 1'b1;
        @(posedge clk);
        #1 csumClear_in = 1'b0;
        @(negedge clk);
        check("clear_exit_csum", checksum_out, 64'd5);
        wait_cycles(10);
        check("clear_final_csum", checksum_out, 64'd18);
        check("clear_rdptr", 64'(rdPtr_out), 64'd1);

        // Asynchronous reset between a read and its data return
        do_reset(1, 256, 0, 1);
        wait_read(3);
        reset_in = 1'b1;
        #1;
        check("arst_rden", 64'(memRdEn_out), 64'd0);
        check("arst_addr", 64'(memAddr_out), 64'd0);
        check("arst_rdptr", 64'(rdPtr_out), 64'd0);
        check("arst_upd", 64'(rdPtrUpdate_out), 64'd0);
        check("arst_valid", 64'(strmValid_out), 64'd0);
        check("arst_data", strmData_out, 64'd0);
        check("arst_csum", checksum_out, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_in = 1'b0;
        base = addr_log.size();
        wait_cycles(30);
        check("arst_restart_reads", 64'(addr_log.size() - base), 64'd8);
        if (addr_log.size() > base)
            check("arst_restart_addr0", 64'(addr_log[base]), 64'd0);
        check("arst_restart_csum", checksum_out, 64'd28);
        check("arst_restart_rdptr", 64'(rdPtr_out), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
